// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS core. Tracks EX/MEM/WB
// destination shadows and derives stall, bubble and operand-forwarding selects.
module hazard_fwd_unit #(
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_is_branch,
    input  logic [REG_BITS-1:0] id_dest,
    input  logic                id_wr,
    input  logic                id_load,
    output logic                stall,
    output logic                bubble,
    output logic [1:0]          fwd_a_ex,
    output logic [1:0]          fwd_b_ex,
    output logic                fwd_a_id,
    output logic                fwd_b_id,
    output logic [CNT_W-1:0]    stall_cycles
);

    logic                r_ex_valid;
    logic [REG_BITS-1:0] r_ex_rs;
    logic [REG_BITS-1:0] r_ex_rt;
    logic                r_ex_use_rs;
    logic                r_ex_use_rt;
    logic [REG_BITS-1:0] r_ex_dest;
    logic                r_ex_wr;
    logic                r_ex_load;
    logic [REG_BITS-1:0] r_mem_dest;
    logic                r_mem_wr;
    logic                r_mem_load;
    logic [REG_BITS-1:0] r_wb_dest;
    logic                r_wb_wr;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_rs_ex;
    logic                w_rt_ex;
    logic                w_rs_mem;
    logic                w_rt_mem;
    logic                w_load_use;
    logic                w_branch_haz;
    logic                w_hazard;
    logic [1:0]          w_fa_ex;
    logic [1:0]          w_fb_ex;

    // Register 0 is hard-wired to zero, so a write to it is never a producer.
    function automatic logic f_match(input logic [REG_BITS-1:0] x,
                                     input logic [REG_BITS-1:0] dest,
                                     input logic                wr);
        return wr && (dest != '0) && (dest == x);
    endfunction

    always_comb begin
        w_rs_ex      = id_use_rs & f_match(id_rs, r_ex_dest, r_ex_wr);
        w_rt_ex      = id_use_rt & f_match(id_rt, r_ex_dest, r_ex_wr);
        w_rs_mem     = id_use_rs & f_match(id_rs, r_mem_dest, r_mem_wr);
        w_rt_mem     = id_use_rt & f_match(id_rt, r_mem_dest, r_mem_wr);
        w_load_use   = r_ex_load & (w_rs_ex | w_rt_ex);
        w_branch_haz = id_is_branch & ((w_rs_ex | w_rt_ex) | (r_mem_load & (w_rs_mem | w_rt_mem)));
        w_hazard     = rst_n & id_valid & (w_load_use | w_branch_haz);
    end

    // MEM result is younger than WB, so it wins when both hold the register.
    always_comb begin
        w_fa_ex = 2'b00;
        w_fb_ex = 2'b00;
        if (r_ex_valid && r_ex_use_rs) begin
            if (f_match(r_ex_rs, r_mem_dest, r_mem_wr))
                w_fa_ex = 2'b01;
            else if (f_match(r_ex_rs, r_wb_dest, r_wb_wr))
                w_fa_ex = 2'b10;
        end
        if (r_ex_valid && r_ex_use_rt) begin
            if (f_match(r_ex_rt, r_mem_dest, r_mem_wr))
                w_fb_ex = 2'b01;
            else if (f_match(r_ex_rt, r_wb_dest, r_wb_wr))
                w_fb_ex = 2'b10;
        end
    end

    assign stall        = w_hazard;
    assign bubble       = w_hazard;
    assign fwd_a_ex     = rst_n ? w_fa_ex : 2'b00;
    assign fwd_b_ex     = rst_n ? w_fb_ex : 2'b00;
    // WB needs no ID path: the register file writes before it is read.
    assign fwd_a_id     = rst_n & id_is_branch & w_rs_mem & ~r_mem_load;
    assign fwd_b_id     = rst_n & id_is_branch & w_rt_mem & ~r_mem_load;
    assign stall_cycles = rst_n ? r_stall_cnt : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_use_rs <= 1'b0;
            r_ex_use_rt <= 1'b0;
            r_ex_dest   <= '0;
            r_ex_wr     <= 1'b0;
            r_ex_load   <= 1'b0;
            r_mem_dest  <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_load  <= 1'b0;
            r_wb_dest   <= '0;
            r_wb_wr     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_wb_dest  <= r_mem_dest;
            r_wb_wr    <= r_mem_wr;
            r_mem_dest <= r_ex_dest;
            r_mem_wr   <= r_ex_wr;
            r_mem_load <= r_ex_load;
            if (id_valid && !w_hazard) begin
                r_ex_valid  <= 1'b1;
                r_ex_rs     <= id_rs;
                r_ex_rt     <= id_rt;
                r_ex_use_rs <= id_use_rs;
                r_ex_use_rt <= id_use_rt;
                r_ex_dest   <= id_dest;
                r_ex_wr     <= id_wr;
                r_ex_load   <= id_load;
            end else begin
                // Bubble is fully zeroed so EX never depends on idle ID fields.
                r_ex_valid  <= 1'b0;
                r_ex_rs     <= '0;
                r_ex_rt     <= '0;
                r_ex_use_rs <= 1'b0;
                r_ex_use_rt <= 1'b0;
                r_ex_dest   <= '0;
                r_ex_wr     <= 1'b0;
                r_ex_load   <= 1'b0;
            end
            if (w_hazard && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed pipeline sequences from a vector table,
// reset corner cases, then random traffic against an instruction-level model.
module tb_hazard_fwd_unit;

  localparam int RB = 5;
  // Narrow counter so saturation is reachable in a short run.
  localparam int CW = 6;
  localparam int OW = 8 + CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid;
  logic [RB-1:0] id_rs, id_rt, id_dest;
  logic          id_use_rs, id_use_rt, id_is_branch, id_wr, id_load;
  logic          stall, bubble, fwd_a_id, fwd_b_id;
  logic [1:0]    fwd_a_ex, fwd_b_ex;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_fwd_unit #(.REG_BITS(RB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
    .id_dest(id_dest), .id_wr(id_wr), .id_load(id_load), .stall(stall), .bubble(bubble),
    .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex), .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id),
    .stall_cycles(stall_cycles)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [RB-1:0] rs, rt, dest;
    logic          use_rs, use_rt, br, wr, ld;
  } instr_t;

  typedef struct {
    instr_t        in;
    logic [OW-1:0] exp;
  } vec_t;

  function automatic instr_t nop_i();
    instr_t i = '{default: '0};
    return i;
  endfunction

  function automatic instr_t alu_i(int d, int s, int t);
    instr_t i = '{default: '0};
    i.valid = 1'b1; i.rs = RB'(s); i.rt = RB'(t); i.dest = RB'(d);
    i.use_rs = 1'b1; i.use_rt = 1'b1; i.wr = 1'b1;
    return i;
  endfunction

  function automatic instr_t lw_i(int d, int base);
    instr_t i = '{default: '0};
    i.valid = 1'b1; i.rs = RB'(base); i.dest = RB'(d);
    i.use_rs = 1'b1; i.wr = 1'b1; i.ld = 1'b1;
    return i;
  endfunction

  function automatic instr_t beq_i(int s, int t);
    instr_t i = '{default: '0};
    i.valid = 1'b1; i.rs = RB'(s); i.rt = RB'(t);
    i.use_rs = 1'b1; i.use_rt = 1'b1; i.br = 1'b1;
    return i;
  endfunction

  function automatic instr_t rnd_i();
    instr_t i;
    i.valid  = ($urandom_range(0, 9) != 0);
    i.rs     = RB'($urandom_range(0, 7));
    i.rt     = RB'($urandom_range(0, 7));
    i.dest   = RB'($urandom_range(0, 7));
    i.use_rs = 1'($urandom_range(0, 1));
    i.use_rt = 1'($urandom_range(0, 1));
    i.br     = ($urandom_range(0, 3) == 0);
    i.wr     = ($urandom_range(0, 3) != 0);
    i.ld     = i.wr && ($urandom_range(0, 2) == 0);
    return i;
  endfunction

  function automatic logic [OW-1:0] pk(logic s, logic [1:0] fa, logic [1:0] fb,
                                       logic ia, logic ib, int cnt);
    return {s, s, fa, fb, ia, ib, CW'(cnt)};
  endfunction

  function automatic vec_t mk(instr_t i, logic [OW-1:0] e);
    vec_t v;
    v.in = i; v.exp = e;
    return v;
  endfunction

  function automatic logic [OW-1:0] act_bus();
    return {stall, bubble, fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, stall_cycles};
  endfunction

  // driver tasks
  task automatic drive(input instr_t i);
    id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_dest = i.dest;
    id_use_rs = i.use_rs; id_use_rt = i.use_rt; id_is_branch = i.br;
    id_wr = i.wr; id_load = i.ld;
  endtask

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h (stall,bubble,fa,fb,ia,ib,cnt) expected %h", name, act, exp);
  endtask

  task automatic step(input string name, input instr_t i, input logic [OW-1:0] exp);
    drive(i);
    @(negedge clk);
    check(name, act_bus(), exp);
    @(posedge clk);
    #1;
  endtask

  // reference model: instructions in flight, index 0=EX, 1=MEM, 2=WB
  instr_t        m_pipe[3];
  int            m_cnt;
  logic [OW-1:0] exp_q[$];

  function automatic logic writes(instr_t s, logic [RB-1:0] r);
    return s.wr && (r != 0) && (s.dest == r);
  endfunction

  function automatic logic reads_from(instr_t i, instr_t s);
    return (i.use_rs && writes(s, i.rs)) || (i.use_rt && writes(s, i.rt));
  endfunction

  function automatic logic m_stall(instr_t i);
    logic dep_ex  = reads_from(i, m_pipe[0]);
    logic dep_mem = reads_from(i, m_pipe[1]);
    return i.valid && ((m_pipe[0].ld && dep_ex) || (i.br && (dep_ex || (m_pipe[1].ld && dep_mem))));
  endfunction

  function automatic logic [1:0] ex_src(logic use_r, logic [RB-1:0] r);
    if (!m_pipe[0].valid || !use_r) return 2'd0;
    if (writes(m_pipe[1], r)) return 2'd1;
    if (writes(m_pipe[2], r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic id_src(instr_t i, logic use_r, logic [RB-1:0] r);
    return i.br && use_r && writes(m_pipe[1], r) && !m_pipe[1].ld;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) m_pipe[k] = nop_i();
    m_cnt = 0;
  endtask

  task automatic m_advance(input instr_t i, input logic st);
    if (st && m_cnt < (1 << CW) - 1) m_cnt++;
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = (i.valid && !st) ? i : nop_i();
  endtask

  task automatic mstep(input instr_t i, input logic rst);
    logic st;
    logic [OW-1:0] e;
    rst_n = ~rst;
    drive(i);
    st = m_stall(i) && !rst;
    e = rst ? '0 : pk(st, ex_src(m_pipe[0].use_rs, m_pipe[0].rs), ex_src(m_pipe[0].use_rt, m_pipe[0].rt),
                      id_src(i, i.use_rs, i.rs), id_src(i, i.use_rt, i.rt), m_cnt);
    exp_q.push_back(e);
    @(negedge clk);
    check("model", act_bus(), exp_q.pop_front());
    @(posedge clk);
    if (rst) m_reset();
    else m_advance(i, st);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[23];

  initial begin
    tbl[0]  = mk(lw_i(5, 0),      pk(0, 0, 0, 0, 0, 0));
    tbl[1]  = mk(alu_i(6, 5, 7),  pk(1, 0, 0, 0, 0, 0));
    tbl[2]  = mk(alu_i(6, 5, 7),  pk(0, 0, 0, 0, 0, 1));
    tbl[3]  = mk(nop_i(),         pk(0, 2, 0, 0, 0, 1));
    tbl[4]  = mk(alu_i(3, 1, 2),  pk(0, 0, 0, 0, 0, 1));
    tbl[5]  = mk(alu_i(4, 3, 3),  pk(0, 0, 0, 0, 0, 1));
    tbl[6]  = mk(alu_i(10, 3, 11), pk(0, 1, 1, 0, 0, 1));
    tbl[7]  = mk(nop_i(),         pk(0, 2, 0, 0, 0, 1));
    tbl[8]  = mk(alu_i(0, 1, 2),  pk(0, 0, 0, 0, 0, 1));
    tbl[9]  = mk(alu_i(12, 0, 0), pk(0, 0, 0, 0, 0, 1));
    tbl[10] = mk(nop_i(),         pk(0, 0, 0, 0, 0, 1));
    tbl[11] = mk(alu_i(8, 1, 2),  pk(0, 0, 0, 0, 0, 1));
    tbl[12] = mk(alu_i(8, 1, 2),  pk(0, 0, 0, 0, 0, 1));
    tbl[13] = mk(alu_i(13, 8, 1), pk(0, 0, 0, 0, 0, 1));
    tbl[14] = mk(nop_i(),         pk(0, 1, 0, 0, 0, 1));
    tbl[15] = mk(lw_i(9, 0),      pk(0, 0, 0, 0, 0, 1));
    tbl[16] = mk(beq_i(9, 1),     pk(1, 0, 0, 0, 0, 1));
    tbl[17] = mk(beq_i(9, 1),     pk(1, 0, 0, 0, 0, 2));
    tbl[18] = mk(beq_i(9, 1),     pk(0, 0, 0, 0, 0, 3));
    tbl[19] = mk(alu_i(9, 1, 2),  pk(0, 0, 0, 0, 0, 3));
    tbl[20] = mk(beq_i(9, 1),     pk(1, 0, 0, 0, 0, 3));
    tbl[21] = mk(beq_i(9, 1),     pk(0, 0, 0, 1, 0, 4));
    tbl[22] = mk(nop_i(),         pk(0, 2, 0, 0, 0, 4));

    drive(nop_i());
    m_reset();
    @(posedge clk);
    #1;

    // two reset cycles with hazard-looking ID traffic: everything must read 0
    rst_n = 1'b0;
    step("rst_hold0", lw_i(5, 0), '0);
    step("rst_hold1", beq_i(5, 5), '0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step("post_rst", nop_i(), '0);

    for (int k = 0; k < 23; k++) step($sformatf("vec%0d", k), tbl[k].in, tbl[k].exp);

    // reset lands on the second cycle of a lw/beq stall
    step("mid_lw",   lw_i(9, 0),  pk(0, 0, 0, 0, 0, 4));
    step("mid_beq1", beq_i(9, 1), pk(1, 0, 0, 0, 0, 4));
    rst_n = 1'b0;
    step("mid_rst",  beq_i(9, 1), '0);
    rst_n = 1'b1;
    step("mid_after", beq_i(9, 1), pk(0, 0, 0, 0, 0, 0));
    step("mid_ex",    nop_i(),     pk(0, 0, 0, 0, 0, 0));

    // random traffic against the model, with occasional resets
    mstep(nop_i(), 1'b1);
    for (int k = 0; k < 1200; k++) mstep(rnd_i(), ($urandom_range(0, 49) == 0));

    // enough load-use pairs to pin the counter at all-ones
    for (int k = 0; k < 70; k++) begin
      mstep(lw_i(5, 0), 1'b0);
      mstep(alu_i(6, 5, 5), 1'b0);
      mstep(alu_i(6, 5, 5), 1'b0);
    end
    mstep(nop_i(), 1'b0);
    @(negedge clk);
    check("cnt_sat", OW'(stall_cycles), OW'({CW{1'b1}}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Keeps a shadow record of in-flight destination registers for EX, MEM and WB, taken from the ID-stage decode fields.
- Uses 5-bit register-number equality (rs/rt against dest) to drive IF/ID stall, the ID/EX bubble, EX-stage forwarding selects and ID-stage branch-operand forwarding.
- Sits beside the ID/EX pipeline register; its outputs feed the PC/IF-ID enables and the operand muxes.

Parameters:
- REG_BITS, 5, register-number width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  synchronous active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_BITS  ID source register A.
- id_rt  input  REG_BITS  ID source register B.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_is_branch  input  1  branch/compare resolved in ID; needs operands in ID.
- id_dest  input  REG_BITS  ID instruction destination register.
- id_wr  input  1  ID instruction writes the register file.
- id_load  input  1  ID instruction is a load.
- stall  output  1  hold PC and IF/ID.
- bubble  output  1  load NOP into ID/EX.
- fwd_a_ex  output  2  EX operand A select: 00 regfile, 01 MEM result, 10 WB result.
- fwd_b_ex  output  2  same encoding, operand B.
- fwd_a_id  output  1  ID branch operand A taken from MEM result.
- fwd_b_id  output  1  same, operand B.
- stall_cycles  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset and outputs:
  - Reset is synchronous, active-low, on one clock, and applies only at the rising edge of clk.
  - While rst_n=0, all outputs are driven 0.
  - On a clk edge with rst_n=0: EX/MEM/WB slots are cleared (wr=0, load=0, regs=0) and stall_cycles=0.
  - Reset asserted mid-stall drops stall the same cycle; pending hazards are discarded.
- Slots:
  - EX slot holds {valid, rs, rt, use_rs, use_rt, dest, wr, load}.
  - MEM slot holds {dest, wr, load}.
  - WB slot holds {dest, wr}.
- Slot advance, every edge with rst_n=1:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields if stall=0 and id_valid=1; otherwise EX is loaded as a bubble (valid=0, wr=0, load=0).
- Match definition: match(x, slot) = slot.wr & (slot.dest != 0) & (slot.dest == x). Register 0 never matches.
- Load-use hazard: EX.load & ((id_use_rs & match(id_rs, EX)) | (id_use_rt & match(id_rt, EX))).
- Branch hazard (id_is_branch=1): either condition stalls.
  - Any used source matches EX (load or not).
  - A used source matches MEM with MEM.load=1.
- stall = bubble = id_valid & (load-use hazard | branch hazard). Combinational, same cycle.
- Stall duration:
  - Load-use stalls exactly 1 cycle.
  - Branch after ALU op stalls 1 cycle.
  - Branch after load stalls 2 cycles.
  - Duration follows naturally from the slots advancing; there is no separate timer.
- EX forwarding (combinational from registered EX slot, valid the cycle the instruction is in EX):
  - fwd_a_ex = 01 if EX.use_rs & match(EX.rs, MEM); else 10 if EX.use_rs & match(EX.rs, WB); else 00.
  - MEM has priority over WB when both match.
  - fwd_b_ex follows the same rule using rt.
  - fwd_*_ex = 00 when EX.valid=0.
- ID forwarding:
  - fwd_a_id = id_is_branch & id_use_rs & match(id_rs, MEM) & ~MEM.load. B analogous with rt.
  - No ID forward from WB; the register file writes first half / reads second half.
- stall_cycles increments by 1 on each edge where stall=1 and rst_n=1, and holds at all-ones.
- No internal state depends on id_* while id_valid=0, except the EX bubble insertion.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release → all outputs 0; fwd_*_ex=00 for the first 3 cycles.
- `lw $5` then `add $6,$5,$7` → stall=bubble=1 for exactly 1 cycle. After the stall, add in EX sees fwd_a_ex=10 (the load is now in WB). stall_cycles=1.
- `add $3,$1,$2` then `sub $4,$3,$3` → no stall. In EX, sub gets fwd_a_ex=fwd_b_ex=01. A third independent instruction then reading $3 in EX gets 10.
- `add $0,...` followed by a reader of $0 → no stall, fwd=00. Also: `add $8` in MEM and `or $8` in WB both writing $8, reader in EX → fwd_a_ex=01 (MEM wins).
- `lw $9` then `beq $9,$1` → stall for 2 cycles. Then fwd_a_id=0 because $9 is in WB (regfile path). With `add $9` instead of `lw $9` → 1 stall cycle, then fwd_a_id=1.
- Assert rst_n=0 during the second cycle of a `lw`/`beq` stall → stall=0 that cycle. After release, beq proceeds with no stall and stall_cycles=0.
